id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Parametrised successor to the MIPS decode front-end. It registers the fetch PC and keeps the synchronous-SRAM instruction word alive across stalls with a hold register managed by a 3-state FSM. It resolves rs/rt operands through NUM_FWD prioritised forwarding sources plus a WB bypass, and raises a load-use interlock. It sits between IF and the combinational decoder/branch unit, and feeds the ID→EX bus.

## Interface
- NUM_FWD, 2: number of in-flight forwarding sources; index 0 is youngest (EX), then MEM, and so on.
- DW, 32: data and instruction width.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard the current ID instruction (exception or redirect)
- stall_in  in  1  downstream hold; ID must not advance
- if_valid  in  1  IF presents pc this cycle
- if_pc  in  DW  fetch PC
- if_ready  out  1  ID accepts if_pc this cycle
- inst_rdata  in  DW  SRAM read data; valid the cycle after acceptance
- fwd_we  in  NUM_FWD  per-source write enable
- fwd_waddr  in  5*NUM_FWD  per-source destination; source i at [5i+4:5i]
- fwd_wdata  in  DW*NUM_FWD  per-source result
- fwd_is_load  in  NUM_FWD  source result not yet available (load in flight)
- wb_we / wb_waddr / wb_wdata  in  1/5/DW  writeback port, same-cycle bypass
- rf_raddr1, rf_raddr2  out  5  regfile read addresses; equal inst[25:21] and inst[20:16]
- rf_rdata1, rf_rdata2  in  DW  regfile read data
- rs_used, rt_used  in  1  decoder operand-use flags for id_inst
- id_valid  out  1  ID holds a live instruction
- id_pc, id_inst  out  DW  current PC and instruction
- rs_val, rt_val  out  DW  resolved operands
- stallreq  out  1  load-use interlock request
- stall_cnt  out  16  interlock cycle counter, saturating

## Operation
- FSM states: EMPTY, LIVE (id_inst = inst_rdata), HELD (id_inst = hold_r).
- advance = id_valid & ~stall_in & ~stallreq.
- if_ready = ~id_valid | advance.
- Acceptance: if_valid & if_ready loads pc_r and moves the FSM to LIVE.
- EMPTY → LIVE on acceptance. Otherwise stay in EMPTY.
- LIVE with ~advance → HELD, and hold_r captures inst_rdata.
- LIVE with advance → LIVE if if_valid, else EMPTY.
- HELD with ~advance → HELD; hold_r is unchanged.
- HELD with advance → LIVE if if_valid, else EMPTY.
- flush → EMPTY. flush beats acceptance: a same-cycle if_valid is dropped. rst beats flush.
- id_valid = (state != EMPTY). id_inst is 0 in EMPTY.
- Operand resolution for rs (rt is identical), priority order:
  - address 0 → 0, never forwarded;
  - else the lowest index i with fwd_we[i] & fwd_waddr[i]==rs → fwd_wdata[i];
  - else wb_we & wb_waddr==rs → wb_wdata;
  - else rf_rdata1.
- Interlock: stallreq = id_valid & ((rs_used & rs≠0 & youngest rs match is_load) | (rt_used & rt≠0 & youngest rt match is_load)).
- A younger non-load match masks an older load match, so there is no stall in that case.
- stall_cnt increments on every cycle stallreq=1 and saturates at 0xFFFF. It is not cleared by flush.

## Timing
- Reset values: state EMPTY, pc_r 0, hold_r 0, stall_cnt 0. After reset: id_valid 0, id_pc 0, id_inst 0, stallreq 0, if_ready 1.
- Latency: PC accepted at edge N; id_pc, id_inst and operands are valid in cycle N+1.
- Operand and stallreq paths are combinational from fwd_*, wb_* and rf_rdata*; no register sits on them.
- Back-to-back: a HELD instruction advancing while if_valid=1 yields LIVE next cycle with no bubble.
- Flush while HELD discards hold_r contents; the next accepted instruction reads SRAM normally.

## Configuration
- ID_LOAD_USE_INTERLOCK_EN defined: stallreq behaves as specified.
- ID_LOAD_USE_INTERLOCK_EN undefined:
  - stallreq is tied 0 and fwd_is_load is ignored;
  - a matching load source forwards fwd_wdata as-is;
  - stall_cnt stays 0.

## Test plan
- Reset, then accept pc 0xBFC00000 with inst 0x24080005 → next cycle id_valid=1, id_pc=0xBFC00000, id_inst=0x24080005, stallreq=0.
- In LIVE, raise stall_in for 3 cycles while SRAM drives 0xDEADBEEF after the edge → id_inst holds the original word for 3 cycles, state is HELD, if_ready=0, and the instruction advances on the 4th cycle.
- rs=8 with fwd0 (8, 0x11), fwd1 (8, 0x22) and wb (8, 0x33) all writing → rs_val=0x11. Drop fwd0 → 0x22. Drop fwd1 → 0x33.
- rs=0 with every source writing r0 = 0xFFFFFFFF → rs_val=0.
- rt_used=1 with fwd0 (rt, is_load=1) → stallreq=1 and stall_cnt increments. Set fwd0 non-load while fwd1 remains a load on rt → stallreq=0. Hold stallreq for 70000 cycles → stall_cnt=0xFFFF.
- flush together with if_valid in HELD → next cycle id_valid=0, id_inst=0, and the dropped PC never appears.

Source files
------------

// File: rtl/id_operand_stage.sv
// ID front-end: PC register, SRAM hold FSM, operand forwarding, load-use interlock.
// Optional feature macro: ID_LOAD_USE_INTERLOCK_EN (undefined: stallreq tied 0).
module id_operand_stage #(
  parameter int NUM_FWD = 2,
  parameter int DW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall_in,
  input  logic                 if_valid,
  input  logic [DW-1:0]        if_pc,
  output logic                 if_ready,
  input  logic [DW-1:0]        inst_rdata,
  input  logic [NUM_FWD-1:0]   fwd_we,
  input  logic [5*NUM_FWD-1:0] fwd_waddr,
  input  logic [DW*NUM_FWD-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]   fwd_is_load,
  input  logic                 wb_we,
  input  logic [4:0]           wb_waddr,
  input  logic [DW-1:0]        wb_wdata,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [DW-1:0]        rf_rdata1,
  input  logic [DW-1:0]        rf_rdata2,
  input  logic                 rs_used,
  input  logic                 rt_used,
  output logic                 id_valid,
  output logic [DW-1:0]        id_pc,
  output logic [DW-1:0]        id_inst,
  output logic [DW-1:0]        rs_val,
  output logic [DW-1:0]        rt_val,
  output logic                 stallreq,
  output logic [15:0]          stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_LIVE  = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_hold;
  logic [15:0]   r_stall_cnt;
  logic [DW-1:0] w_inst;
  logic          w_advance;
  logic          w_accept;
  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic          w_rs_hit;
  logic          w_rt_hit;
  logic          w_rs_ld;
  logic          w_rt_ld;
  logic [DW-1:0] w_rs_fwd;
  logic [DW-1:0] w_rt_fwd;
  logic          w_stallreq;

  assign id_valid  = (r_state != S_EMPTY);
  assign w_advance = id_valid & ~stall_in & ~w_stallreq;
  assign if_ready  = ~id_valid | w_advance;
  assign w_accept  = if_valid & if_ready;

  // Instruction word: live SRAM data, or the captured copy while stalled
  always_comb begin
    w_inst = '0;
    unique case (r_state)
      S_LIVE:  w_inst = inst_rdata;
      S_HELD:  w_inst = r_hold;
      default: w_inst = '0;
    endcase
  end

  // Next state of the hold FSM; flush overrides everything except reset
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY:
          w_state_nxt = w_accept ? S_LIVE : S_EMPTY;
        S_LIVE, S_HELD:
          if (!w_advance)
            w_state_nxt = S_HELD;
          else
            w_state_nxt = if_valid ? S_LIVE : S_EMPTY;
        default:
          w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State, PC and hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_pc    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && !flush)
        r_pc <= if_pc;
      if (r_state == S_LIVE && !w_advance && !flush)
        r_hold <= inst_rdata;
    end
  end

  assign id_pc     = r_pc;
  assign id_inst   = w_inst;
  assign w_rs      = w_inst[25:21];
  assign w_rt      = w_inst[20:16];
  assign rf_raddr1 = w_rs;
  assign rf_raddr2 = w_rt;

  // Youngest matching forwarding source wins (scan oldest to youngest)
  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    w_rs_ld  = 1'b0;
    w_rt_ld  = 1'b0;
    w_rs_fwd = '0;
    w_rt_fwd = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_waddr[5*i +: 5] == w_rs) begin
        w_rs_hit = 1'b1;
        w_rs_ld  = fwd_is_load[i];
        w_rs_fwd = fwd_wdata[DW*i +: DW];
      end
      if (fwd_we[i] && fwd_waddr[5*i +: 5] == w_rt) begin
        w_rt_hit = 1'b1;
        w_rt_ld  = fwd_is_load[i];
        w_rt_fwd = fwd_wdata[DW*i +: DW];
      end
    end
  end

  // Operand select: r0, in-flight source, WB bypass, regfile
  always_comb begin
    rs_val = rf_rdata1;
    rt_val = rf_rdata2;
    if (w_rs == 5'd0)
      rs_val = '0;
    else if (w_rs_hit)
      rs_val = w_rs_fwd;
    else if (wb_we && wb_waddr == w_rs)
      rs_val = wb_wdata;
    if (w_rt == 5'd0)
      rt_val = '0;
    else if (w_rt_hit)
      rt_val = w_rt_fwd;
    else if (wb_we && wb_waddr == w_rt)
      rt_val = wb_wdata;
  end

`ifdef ID_LOAD_USE_INTERLOCK_EN
  assign w_stallreq = id_valid &
    ((rs_used & (w_rs != 5'd0) & w_rs_ld) |
     (rt_used & (w_rt != 5'd0) & w_rt_ld));
`else
  logic w_unused;
  assign w_unused   = ^{w_rs_ld, w_rt_ld, rs_used, rt_used};
  assign w_stallreq = 1'b0;
`endif

  assign stallreq = w_stallreq;

  // Saturating count of interlock cycles; survives flush
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stallreq && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage.
// Expectations follow ID_LOAD_USE_INTERLOCK_EN when it is defined.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, stall_in, if_valid, if_ready;
  logic [31:0] if_pc, inst_rdata;
  logic [1:0]  fwd_we, fwd_is_load;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rs_used, rt_used, id_valid, stallreq;
  logic [31:0] id_pc, id_inst, rs_val, rt_val;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_operand_stage #(.NUM_FWD(2), .DW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .if_valid(if_valid), .if_pc(if_pc), .if_ready(if_ready),
    .inst_rdata(inst_rdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rs_used(rs_used), .rt_used(rt_used), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .rs_val(rs_val), .rt_val(rt_val),
    .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; stall_in = 0; if_valid = 0; if_pc = 0;
    inst_rdata = 0; fwd_we = 0; fwd_waddr = 0; fwd_wdata = 0;
    fwd_is_load = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    rf_rdata1 = 0; rf_rdata2 = 0; rs_used = 0; rt_used = 0;
    tick(); tick();
    rst = 0;
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_valid got %h want 0", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_err++;
      $display("FAIL rst_pc got %h want 0", id_pc); end
    n_cmp++; if (id_inst !== 32'h0) begin n_err++;
      $display("FAIL rst_inst got %h want 0", id_inst); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++;
      $display("FAIL rst_stallreq got %h want 0", stallreq); end
    n_cmp++; if (if_ready !== 1'b1) begin n_err++;
      $display("FAIL rst_ready got %h want 1", if_ready); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_err++;
      $display("FAIL rst_cnt got %h want 0", stall_cnt); end
  endtask

  task automatic test_accept();
    if_valid = 1; if_pc = 32'hBFC00000;
    tick();
    if_valid = 0; inst_rdata = 32'h24080005;
    #1;
    n_cmp++; if (id_valid !== 1'b1) begin n_err++;
      $display("FAIL acc_valid got %h want 1", id_valid); end
    n_cmp++; if (id_pc !== 32'hBFC00000) begin n_err++;
      $display("FAIL acc_pc got %h want bfc00000", id_pc); end
    n_cmp++; if (id_inst !== 32'h24080005) begin n_err++;
      $display("FAIL acc_inst got %h want 24080005", id_inst); end
    n_cmp++; if (stallreq !== 1'b0) begin n_err++;
      $display("FAIL acc_stallreq got %h want 0", stallreq); end
    n_cmp++; if (rf_raddr2 !== 5'd8) begin n_err++;
      $display("FAIL acc_raddr2 got %h want 8", rf_raddr2); end
    tick();
    n_cmp++; if (id_valid !== 1'b0) begin n_err++;
      $display("FAIL acc_drain got %h want 0", id_valid); end
  endtask

  task automatic test_stall_hold();
    if_valid = 1; if_pc = 32'h100;
    tick();
    if_valid = 0; inst_rdata = 32'h01095020; stall_in = 1;
    #1;
    n_cmp++; if (if_ready !== 1'b0) begin n_err++;
      $display("FAIL hold_ready0 got %h want 0", if_ready); end
    for (int c = 1; c < 3; c++) begin
      tick();
      inst_rdata = 32'hDEADBEEF;
      #1;
      n_cmp++; if (id_inst !== 32'h01095020) begin n_err++;
        $display("FAIL hold_inst%0d got %h want 01095020", c, id_inst); end
      n_cmp++; if (if_ready !== 1'b0) begin n_err++;
        $display("FAIL hold_ready%0d got %h want 0", c, if_ready); end
    end
    tick();
    stall_in = 0; if_valid = 1; if_pc = 32'h104;
    #1;
    n_cmp++; if (id_inst !== 32'h01095020) begin n_err++;
      $display("FAIL hold_inst3 got %h want 01095020", id_inst); end
    n_cmp++; if (if_ready !== 1'b1) begin n_err++;
      $display("FAIL hold_release got %h want 1", if_ready); end
  endtask

  task automatic test_back_to_back();
    tick();
    if_valid = 0; inst_rdata = 32'h00000022;
    #1;
    n_cmp++; if (id_valid !== 1'b1) begin n_err++;
      $display("FAIL b2b_valid got %h want 1", id_valid); end
    n_cmp++; if (id_pc !== 32'h104) begin n_err++;
      $display("FAIL b2b_pc got %h want 104", id_pc); end
    n_cmp++; if (id_inst !== 32'h00000022) begin n_err++;
      $display("FAIL b2b_inst got %h want 22", id_inst); end
    tick();
  endtask

  task automatic test_forward();
    if_valid = 1; if_pc = 32'h200;
    tick();
    if_valid = 0; inst_rdata = 32'h01095020; stall_in = 1;
    rf_rdata1 = 32'h44; rf_rdata2 = 32'h55;
    fwd_we = 2'b11; fwd_waddr = {5'd8, 5'd8};
    fwd_wdata = {32'h22, 32'h11};
    wb_we = 1; wb_waddr = 5'd8; wb_wdata = 32'h33;
    #1;
    n_cmp++; if (rs_val !== 32'h11) begin n_err++;
      $display("FAIL fwd_ex got %h want 11", rs_val); end
    n_cmp++; if (rt_val !== 32'h55) begin n_err++;
      $display("FAIL fwd_rt_rf got %h want 55", rt_val); end
    fwd_we = 2'b10;
    #1;
    n_cmp++; if (rs_val !== 32'h22) begin n_err++;
      $display("FAIL fwd_mem got %h want 22", rs_val); end
    fwd_we = 2'b00;
    #1;
    n_cmp++; if (rs_val !== 32'h33) begin n_err++;
      $display("FAIL fwd_wb got %h want 33", rs_val); end
    wb_we = 0;
    #1;
    n_cmp++; if (rs_val !== 32'h44) begin n_err++;
      $display("FAIL fwd_rf got %h want 44", rs_val); end
    tick();
    flush = 1;
    tick();
    flush = 0; stall_in = 0;
  endtask

  task automatic test_zero_reg();
    if_valid = 1; if_pc = 32'h240;
    tick();
    if_valid = 0; inst_rdata = 32'h00094020; stall_in = 1;
    fwd_we = 2'b11; fwd_waddr = 10'd0;
    fwd_wdata = {32'hFFFFFFFF, 32'hFFFFFFFF};
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFFFFFF;
    rf_rdata1 = 32'hFFFFFFFF;
    #1;
    n_cmp++; if (rs_val !== 32'h0) begin n_err++;
      $display("FAIL zero_rs got %h want 0", rs_val); end
    n_cmp++; if (rt_val !== 32'h55) begin n_err++;
      $display("FAIL zero_rt got %h want 55", rt_val); end
    fwd_we = 0; wb_we = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic test_interlock();
    logic [15:0] c0;
    if_valid = 1; if_pc = 32'h280;
    tick();
    if_valid = 0; inst_rdata = 32'h01095020; stall_in = 1;
    rt_used = 1; rs_used = 0;
    fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd9};
    fwd_wdata = {32'h0, 32'h99}; fwd_is_load = 2'b01;
    #1;
    c0 = stall_cnt;
    n_cmp++; if (c0 !== 16'h0) begin n_err++;
      $display("FAIL il_cnt0 got %h want 0", c0); end
    n_cmp++; if (rt_val !== 32'h99) begin n_err++;
      $display("FAIL il_rtval got %h want 99", rt_val); end
`ifdef ID_LOAD_USE_INTERLOCK_EN
    n_cmp++; if (stallreq !== 1'b1) begin n_err++;
      $display("FAIL il_req got %h want 1", stallreq); end
    tick();
    n_cmp++; if (stall_cnt !== 16'h1) begin n_err++;
      $display("FAIL il_cnt1 got %h want 1", stall_cnt); end
`else
    n_cmp++; if (stallreq !== 1'b0) begin n_err++;
      $display("FAIL il_req got %h want 0", stallreq); end
    tick();
    n_cmp++; if (stall_cnt !== 16'h0) begin n_err++;
      $display("FAIL il_cnt1 got %h want 0", stall_cnt); end
`endif
    fwd_we = 2'b11; fwd_waddr = {5'd9, 5'd9};
    fwd_is_load = 2'b10;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_err++;
      $display("FAIL il_mask got %h want 0", stallreq); end
    fwd_waddr = {5'd0, 5'd8}; fwd_we = 2'b01; fwd_is_load = 2'b01;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_err++;
      $display("FAIL il_unused got %h want 0", stallreq); end
    fwd_waddr = {5'd0, 5'd9};
`ifdef ID_LOAD_USE_INTERLOCK_EN
    repeat (70000) @(posedge clk);
    #1;
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_err++;
      $display("FAIL il_sat got %h want ffff", stall_cnt); end
`else
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (stall_cnt !== 16'h0) begin n_err++;
      $display("FAIL il_sat got %h want 0", stall_cnt); end
`endif
    fwd_we = 0; fwd_is_load = 0; rt_used = 0;
    #1;
  endtask

  task automatic test_flush_held();
    stall_in = 1;
    tick();
    stall_in = 0; flush = 1; if_valid = 1; if_pc = 32'hBAD00000;
    tick();
    flush = 0; if_valid = 0;
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++;
      $display("FAIL fl_valid got %h want 0", id_valid); end
    n_cmp++; if (id_inst !== 32'h0) begin n_err++;
      $display("FAIL fl_inst got %h want 0", id_inst); end
    n_cmp++; if (id_pc !== 32'h280) begin n_err++;
      $display("FAIL fl_pc got %h want 280", id_pc); end
    if_valid = 1; if_pc = 32'h300;
    tick();
    if_valid = 0; inst_rdata = 32'h12345678;
    #1;
    n_cmp++; if (id_inst !== 32'h12345678) begin n_err++;
      $display("FAIL fl_next got %h want 12345678", id_inst); end
    n_cmp++; if (id_pc !== 32'h300) begin n_err++;
      $display("FAIL fl_nextpc got %h want 300", id_pc); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_stall_hold();
    test_back_to_back();
    test_forward();
    test_zero_reg();
    test_interlock();
    test_flush_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
